// File: rtl/ssdma_csr_pkg.sv
// Shared constants for the SSDMA register block: offsets, bit positions,
// response encoding and a byte-lane merge helper.
package ssdma_csr_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h5353_4430;

  localparam logic [31:0] OFS_ID       = 32'h00;
  localparam logic [31:0] OFS_CTRL     = 32'h04;
  localparam logic [31:0] OFS_STATUS   = 32'h08;
  localparam logic [31:0] OFS_DESC     = 32'h0C;
  localparam logic [31:0] OFS_DOORBELL = 32'h10;
  localparam logic [31:0] OFS_SCRATCH  = 32'h14;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE_DONE  = 1;
  localparam int CTRL_IE_ERR   = 2;
  localparam int CTRL_SOFT_RST = 31;

  localparam int ST_DONE = 0;
  localparam int ST_ERR  = 1;
  localparam int ST_BUSY = 2;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_ACK  = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_RTY  = 2'd3
  } resp_e;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ssdma_irq_status.sv
// Sticky done/err status bits with write-1-to-clear and the registered
// interrupt request derived from them.
module ssdma_irq_status
  import ssdma_csr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic eng_done_i,
  input  logic eng_err_i,
  input  logic w1c_done_i,
  input  logic w1c_err_i,
  input  logic clr_i,
  input  logic ie_done_i,
  input  logic ie_err_i,
  output logic done_o,
  output logic err_o,
  output logic int_o
);

  logic done_q, done_d;
  logic err_q, err_d;
  logic int_q, int_d;

  // A new event in the same cycle as a clear keeps the bit set.
  always_comb begin
    done_d = eng_done_i | (done_q & ~w1c_done_i & ~clr_i);
    err_d  = eng_err_i  | (err_q  & ~w1c_err_i  & ~clr_i);
    int_d  = (done_q & ie_done_i) | (err_q & ie_err_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      int_q  <= int_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign int_o  = int_q;

endmodule

// File: rtl/ssdma_csr_slave.sv
// Wishbone single-access register slave for the SSDMA engine: control,
// status, descriptor pointer, doorbell and scratch registers.
module ssdma_csr_slave
  import ssdma_csr_pkg::*;
#(
  parameter int          ADDR_W       = 5,
  parameter logic [31:0] ID_VALUE     = ID_DEFAULT,
  parameter bit          UNMAPPED_ERR = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_cab_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        wb_int_o,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic        eng_err_i,
  output logic        start_o,
  output logic [31:0] desc_addr_o
);

  resp_e       resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] desc_q, desc_d;
  logic [31:0] scratch_q, scratch_d;

  logic [31:0] ofs;
  logic [31:0] rd_val;
  logic        cap;
  logic        w1c_done, w1c_err, soft_clr;
  logic        st_done, st_err;
  logic        unused_in;

  assign unused_in = ^{wbs_cab_i, wbs_adr_i[31:ADDR_W], wbs_adr_i[1:0]};

  // Only the decoded offset bits take part; upper address bits alias.
  always_comb begin
    ofs = '0;
    ofs[ADDR_W-1:2] = wbs_adr_i[ADDR_W-1:2];
  end

  assign cap = wbs_cyc_i & wbs_stb_i & (resp_q == RESP_NONE);

  always_comb begin
    resp_d    = RESP_NONE;
    rd_val    = '0;
    rdata_d   = '0;
    start_d   = 1'b0;
    ctrl_d    = ctrl_q;
    desc_d    = desc_q;
    scratch_d = scratch_q;
    w1c_done  = 1'b0;
    w1c_err   = 1'b0;
    soft_clr  = 1'b0;
    if (cap) begin
      resp_d = RESP_ACK;
      unique case (ofs)
        OFS_ID: rd_val = ID_VALUE;
        OFS_CTRL: begin
          rd_val = {29'b0, ctrl_q};
          if (wbs_we_i) begin
            if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[2:0];
            soft_clr = wbs_sel_i[3] & wbs_dat_i[CTRL_SOFT_RST];
          end
        end
        OFS_STATUS: begin
          rd_val = {29'b0, eng_busy_i, st_err, st_done};
          if (wbs_we_i && wbs_sel_i[0]) begin
            w1c_done = wbs_dat_i[ST_DONE];
            w1c_err  = wbs_dat_i[ST_ERR];
          end
        end
        OFS_DESC: begin
          rd_val = desc_q;
          if (wbs_we_i) begin
            desc_d      = apply_sel(desc_q, wbs_dat_i, wbs_sel_i);
            desc_d[1:0] = 2'b00;
          end
        end
        OFS_DOORBELL: begin
          // A doorbell the engine cannot take is bounced back for retry.
          if (wbs_we_i && (|wbs_sel_i)) begin
            if (eng_busy_i || !ctrl_q[CTRL_EN]) resp_d = RESP_RTY;
            else start_d = 1'b1;
          end
        end
        OFS_SCRATCH: begin
          rd_val = scratch_q;
          if (wbs_we_i) scratch_d = apply_sel(scratch_q, wbs_dat_i, wbs_sel_i);
        end
        default: begin
          if (UNMAPPED_ERR) resp_d = RESP_ERR;
        end
      endcase
      if (soft_clr) begin
        ctrl_d = '0;
        desc_d = '0;
      end
      if (!wbs_we_i && resp_d == RESP_ACK) rdata_d = rd_val;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      resp_q    <= RESP_NONE;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      ctrl_q    <= '0;
      desc_q    <= '0;
      scratch_q <= '0;
    end else begin
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      ctrl_q    <= ctrl_d;
      desc_q    <= desc_d;
      scratch_q <= scratch_d;
    end
  end

  ssdma_irq_status u_irq (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .eng_done_i (eng_done_i),
    .eng_err_i  (eng_err_i),
    .w1c_done_i (w1c_done),
    .w1c_err_i  (w1c_err),
    .clr_i      (soft_clr),
    .ie_done_i  (ctrl_q[CTRL_IE_DONE]),
    .ie_err_i   (ctrl_q[CTRL_IE_ERR]),
    .done_o     (st_done),
    .err_o      (st_err),
    .int_o      (wb_int_o)
  );

  // Terminations are withdrawn as soon as the master drops the cycle.
  assign wbs_ack_o   = (resp_q == RESP_ACK) & wbs_cyc_i;
  assign wbs_err_o   = (resp_q == RESP_ERR) & wbs_cyc_i;
  assign wbs_rty_o   = (resp_q == RESP_RTY) & wbs_cyc_i;
  assign wbs_dat_o   = wbs_ack_o ? rdata_q : '0;
  assign start_o     = start_q;
  assign desc_addr_o = desc_q;

endmodule

// File: tb/tb_ssdma_csr_slave.sv
// Directed bench for ssdma_csr_slave: register map, doorbell, interrupt
// and reset scenarios with hand-computed expectations.
module tb_ssdma_csr_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, cab = 1'b0;
  logic [31:0] dat_o;
  logic        ack, err, rty, int_o;
  logic        busy = 1'b0, done_p = 1'b0, err_p = 1'b0;
  logic        start;
  logic [31:0] desc;

  int checks = 0;
  int failures = 0;

  logic        r_pre, r_ack, r_err, r_rty, r_start, r_int;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  ssdma_csr_slave dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_sel_i   (sel),
    .wbs_we_i    (we),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_cab_i   (cab),
    .wbs_dat_o   (dat_o),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .wbs_rty_o   (rty),
    .wb_int_o    (int_o),
    .eng_busy_i  (busy),
    .eng_done_i  (done_p),
    .eng_err_i   (err_p),
    .start_o     (start),
    .desc_addr_o (desc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the response cycle.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic w, input logic pulse_done);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    done_p = pulse_done;
    @(negedge clk);
    r_pre = ack | err | rty;
    @(posedge clk);
    #1 done_p = 1'b0;
    @(negedge clk);
    r_ack = ack; r_err = err; r_rty = rty; r_dat = dat_o; r_start = start; r_int = int_o;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err_rty", {30'b0, err, rty}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_int_start", {30'b0, int_o, start}, 32'h0);
    check("rst_desc", desc, 32'h0);
    #10 rst = 1'b0;
    tick();

    bus(32'h00, 32'h0, 4'hF, 1'b0, 1'b0);
    check("id_pre", {31'b0, r_pre}, 32'h0);
    check("id_ack", {31'b0, r_ack}, 32'h1);
    check("id_dat", r_dat, 32'h5353_4430);
    check("id_err_rty", {30'b0, r_err, r_rty}, 32'h0);
    check("ack_one_cycle", {31'b0, ack}, 32'h0);

    bus(32'h14, 32'hA5A5_A5A5, 4'b0101, 1'b1, 1'b0);
    check("scr_wr_ack", {31'b0, r_ack}, 32'h1);
    check("scr_wr_dat0", r_dat, 32'h0);
    bus(32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
    check("scr_rd", r_dat, 32'h00A5_00A5);

    bus(32'h04, 32'h1, 4'hF, 1'b1, 1'b0);
    bus(32'h10, 32'h1, 4'hF, 1'b1, 1'b0);
    check("db_ack", {31'b0, r_ack}, 32'h1);
    check("db_start", {31'b0, r_start}, 32'h1);
    check("db_start_pulse", {31'b0, start}, 32'h0);
    busy = 1'b1;
    bus(32'h10, 32'h1, 4'hF, 1'b1, 1'b0);
    check("db_busy_rty", {30'b0, r_ack, r_rty}, 32'h1);
    check("db_busy_nostart", {31'b0, r_start}, 32'h0);
    bus(32'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    check("status_busy", r_dat, 32'h4);
    busy = 1'b0;

    bus(32'h04, 32'h3, 4'hF, 1'b1, 1'b0);
    done_p = 1'b1;
    tick();
    done_p = 1'b0;
    tick();
    check("int_on_done", {31'b0, int_o}, 32'h1);
    bus(32'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    check("status_done", r_dat, 32'h1);
    bus(32'h08, 32'h1, 4'hF, 1'b1, 1'b0);
    check("w1c_int_lag", {31'b0, r_int}, 32'h1);
    check("w1c_int_drop", {31'b0, int_o}, 32'h0);
    bus(32'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    check("status_cleared", r_dat, 32'h0);

    done_p = 1'b1;
    tick();
    done_p = 1'b0;
    tick();
    bus(32'h08, 32'h1, 4'hF, 1'b1, 1'b1);
    tick();
    check("set_wins_int", {31'b0, int_o}, 32'h1);
    err_p = 1'b1;
    tick();
    err_p = 1'b0;
    bus(32'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    check("set_wins_status", r_dat, 32'h3);

    bus(32'h0C, 32'h1234_5677, 4'hF, 1'b1, 1'b0);
    check("desc_out", desc, 32'h1234_5674);
    bus(32'h0C, 32'h0, 4'hF, 1'b0, 1'b0);
    check("desc_rd", r_dat, 32'h1234_5674);

    bus(32'h1C, 32'h0, 4'hF, 1'b0, 1'b0);
    check("unmapped_err", {29'b0, r_err, r_ack, r_rty}, 32'h4);
    check("unmapped_dat", r_dat, 32'h0);
    bus(32'h24, 32'h0, 4'hF, 1'b0, 1'b0);
    check("alias_ctrl", r_dat, 32'h3);

    bus(32'h04, 32'h8000_0000, 4'hF, 1'b1, 1'b0);
    check("soft_ack", {31'b0, r_ack}, 32'h1);
    bus(32'h04, 32'h0, 4'hF, 1'b0, 1'b0);
    check("soft_ctrl", r_dat, 32'h0);
    bus(32'h0C, 32'h0, 4'hF, 1'b0, 1'b0);
    check("soft_desc", r_dat, 32'h0);
    check("soft_desc_out", desc, 32'h0);
    bus(32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
    check("soft_scratch", r_dat, 32'h00A5_00A5);
    bus(32'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    check("soft_status", r_dat, 32'h0);
    check("soft_int", {31'b0, int_o}, 32'h0);
    bus(32'h10, 32'h1, 4'hF, 1'b1, 1'b0);
    check("db_disabled_rty", {30'b0, r_ack, r_rty}, 32'h1);
    check("db_disabled_nostart", {31'b0, r_start}, 32'h0);

    adr = 32'h14; wdat = 32'h1122_3344; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("cyc_drop_noack", {31'b0, ack}, 32'h0);
    tick();
    bus(32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
    check("cyc_drop_committed", r_dat, 32'h1122_3344);

    bus(32'h04, 32'h1, 4'hF, 1'b1, 1'b0);
    adr = 32'h10; wdat = 32'h1; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_start", {31'b0, start}, 32'h0);
    check("arst_ack", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #4 rst = 1'b0;
    tick();
    bus(32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
    check("arst_scratch", r_dat, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
